// File: rtl/srff_flag_arbiter.sv
// Round-robin arbiter turning set/clear requests into single-cycle S/R strobes
// for a bank of SR flag flops, plus a bank-wide preset. SRFF_ARB_VERIFY_EN adds Q readback checking.
module srff_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAG  = 8,
  parameter int FLAG_W = $clog2(NFLAG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_op,
  input  logic [NREQ*FLAG_W-1:0] req_idx,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   preset_all,
  input  logic [NFLAG-1:0]       flag_q,
  output logic [NFLAG-1:0]       flag_s,
  output logic [NFLAG-1:0]       flag_r,
  output logic [NFLAG-1:0]       flag_p_n,
  output logic                   done,
  output logic                   err
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, PRESET, GRANT, SETTLE} state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx;
  logic               op_q, op_nx;
  logic [FLAG_W-1:0]  idx_q, idx_nx;
  logic [NFLAG-1:0]   s_nx, r_nx, p_n_nx;
  logic               done_nx, err_nx;

  logic               grant_any;
  logic [PTR_W-1:0]   winner;
  logic               op_in;
  logic [FLAG_W-1:0]  idx_in;
  logic [NFLAG-1:0]   sel_in;
  logic               idx_in_ok, idx_q_ok;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        winner    = PTR_W'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign op_in     = req_op[winner];
  assign idx_in    = req_idx[int'(winner)*FLAG_W +: FLAG_W];
  assign idx_in_ok = int'(idx_in) < NFLAG;
  assign idx_q_ok  = int'(idx_q) < NFLAG;
  assign sel_in    = NFLAG'(1) << idx_in;

  // Grant is withheld while reset is asserted so no request is lost to the reset edge.
  always_comb begin
    req_ready = '0;
    if (rst && state == IDLE && !preset_all && grant_any)
      req_ready[winner] = 1'b1;
  end

`ifdef SRFF_ARB_VERIFY_EN
  logic preset_chk, preset_chk_nx;
  logic bit_q;

  assign bit_q = |(flag_q & (NFLAG'(1) << idx_q));
`else
  logic unused_nc;

  assign unused_nc = ^{flag_q, op_q};
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    op_nx     = op_q;
    idx_nx    = idx_q;
    s_nx      = '0;
    r_nx      = '0;
    p_n_nx    = '1;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
`ifdef SRFF_ARB_VERIFY_EN
    preset_chk_nx = 1'b0;
    if (preset_chk && flag_q != '1)
      err_nx = 1'b1;
`endif

    case (state)
      IDLE: begin
        if (preset_all) begin
          p_n_nx   = '0;
          state_nx = PRESET;
        end else if (grant_any) begin
          op_nx     = op_in;
          idx_nx    = idx_in;
          rr_ptr_nx = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
          state_nx  = GRANT;
          if (idx_in_ok) begin
            if (op_in) s_nx = sel_in;
            else       r_nx = sel_in;
          end
        end
      end
      PRESET: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
`ifdef SRFF_ARB_VERIFY_EN
        preset_chk_nx = 1'b1;
`endif
      end
      GRANT: begin
        if (!idx_q_ok) begin
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
`ifdef SRFF_ARB_VERIFY_EN
          state_nx = SETTLE;
`else
          done_nx  = 1'b1;
          state_nx = IDLE;
`endif
        end
      end
`ifdef SRFF_ARB_VERIFY_EN
      SETTLE: begin
        done_nx  = 1'b1;
        if (bit_q != op_q) err_nx = 1'b1;
        state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op_q     <= 1'b0;
      idx_q    <= '0;
      flag_s   <= '0;
      flag_r   <= '0;
      flag_p_n <= '1;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef SRFF_ARB_VERIFY_EN
      preset_chk <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      op_q     <= op_nx;
      idx_q    <= idx_nx;
      flag_s   <= s_nx;
      flag_r   <= r_nx;
      flag_p_n <= p_n_nx;
      done     <= done_nx;
      err      <= err_nx;
`ifdef SRFF_ARB_VERIFY_EN
      preset_chk <= preset_chk_nx;
`endif
    end
  end

endmodule

// File: tb/tb_srff_flag_arbiter.sv
// Self-checking bench for srff_flag_arbiter: vector table, directed corner sequences,
// and a randomized run against a cycle-schedule reference model. Honours SRFF_ARB_VERIFY_EN.
`timescale 1ns/1ps
module tb_srff_flag_arbiter;

  localparam int NREQ   = 4;
  localparam int NFLAG  = 6;
  localparam int FLAG_W = 3;
  localparam int RN     = 400;
`ifdef SRFF_ARB_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_op = '0;
  logic [NREQ*FLAG_W-1:0] req_idx = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   preset_all = 1'b0;
  logic [NFLAG-1:0]       flag_q;
  logic [NFLAG-1:0]       flag_s, flag_r, flag_p_n;
  logic                   done, err;

  logic [NFLAG-1:0]       bank = '0;
  logic [NFLAG-1:0]       force_clr = '0;

  int total = 0;
  int bad   = 0;

  srff_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ready(req_ready), .preset_all(preset_all), .flag_q(flag_q), .flag_s(flag_s),
    .flag_r(flag_r), .flag_p_n(flag_p_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural SR flag bank with active-low preset.
  always @(posedge clk) bank <= ~flag_p_n | ((bank | flag_s) & ~flag_r);
  assign flag_q = bank & ~force_clr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [NREQ-1:0] oh_req(input int r);
    logic [NREQ-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic drive(input int r, input bit op, input int idx);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_op[r] = op;
    req_idx[r*FLAG_W +: FLAG_W] = FLAG_W'(idx);
  endtask

  // Starts in an IDLE cycle, ends in the done cycle (also IDLE).
  task automatic do_op(input string tag, input int r, input bit op, input int idx,
                       input logic [NFLAG-1:0] es, input logic [NFLAG-1:0] er, input bit eerr);
    drive(r, op, idx);
    #1;
    check({tag, " ready"}, req_ready, oh_req(r));
    cyc();
    req_valid = '0;
    check({tag, " s"}, flag_s, es);
    check({tag, " r"}, flag_r, er);
    check({tag, " early_done"}, done, 1'b0);
    if (VERIFY && idx < NFLAG) begin
      cyc();
      check({tag, " settle_done"}, done, 1'b0);
    end
    cyc();
    check({tag, " done"}, done, 1'b1);
    check({tag, " err"}, err, eerr);
    check({tag, " s_after"}, flag_s | flag_r, 0);
  endtask

  typedef struct {
    int               rq;
    bit               op;
    int               idx;
    logic [NFLAG-1:0] es;
    logic [NFLAG-1:0] er;
    bit               eerr;
  } vec_t;

  vec_t vecs [7];

  logic [NFLAG-1:0] e_s   [RN+4];
  logic [NFLAG-1:0] e_r   [RN+4];
  logic [NFLAG-1:0] e_pn  [RN+4];
  logic             e_done[RN+4];
  logic             e_err [RN+4];

  initial begin
    vecs[0] = '{0, 1'b1, 5, 6'h20, 6'h00, 1'b0};
    vecs[1] = '{1, 1'b0, 5, 6'h00, 6'h20, 1'b0};
    vecs[2] = '{2, 1'b1, 0, 6'h01, 6'h00, 1'b0};
    vecs[3] = '{3, 1'b0, 3, 6'h00, 6'h08, 1'b0};
    vecs[4] = '{0, 1'b1, 7, 6'h00, 6'h00, 1'b1};
    vecs[5] = '{1, 1'b0, 6, 6'h00, 6'h00, 1'b1};
    vecs[6] = '{2, 1'b1, 2, 6'h04, 6'h00, 1'b0};

    // Reset, with a request held to show it is not granted during reset.
    rst = 1'b0;
    req_valid = '1;
    cyc();
    cyc();
    #1;
    check("rst ready", req_ready, 0);
    check("rst s", flag_s, 0);
    check("rst r", flag_r, 0);
    check("rst pn", flag_p_n, 6'h3f);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);

    // Round robin from rr_ptr=0 with everyone requesting.
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = i[0];
      req_idx[i*FLAG_W +: FLAG_W] = FLAG_W'(i);
    end
    for (int n = 0; n < 5; n++) begin
      #1;
      check("rr ready", req_ready, oh_req(n % NREQ));
      cyc();
      check("rr grant_ready", req_ready, 0);
      check("rr s_and_r", flag_s & flag_r, 0);
      check("rr strobe", flag_s | flag_r, 6'(1 << (n % NREQ)));
      if (VERIFY) cyc();
      cyc();
      check("rr done", done, 1'b1);
    end
    req_valid = '0;

    // Vector table; each op starts in the previous op's done cycle.
    for (int v = 0; v < 7; v++)
      do_op($sformatf("vec%0d", v), vecs[v].rq, vecs[v].op, vecs[v].idx,
            vecs[v].es, vecs[v].er, vecs[v].eerr);
    check("vec bank5", bank[5], 1'b0);
    check("vec bank2", bank[2], 1'b1);

    // Reset in the middle of a GRANT.
    drive(0, 1'b1, 3);
    #1;
    cyc();
    check("mid s", flag_s, 6'h08);
    rst = 1'b0;
    cyc();
    check("mid s_off", flag_s, 0);
    check("mid r_off", flag_r, 0);
    check("mid pn", flag_p_n, 6'h3f);
    check("mid done", done, 1'b0);
    #1;
    check("mid ready", req_ready, 0);
    rst = 1'b1;
    req_valid = '0;
    cyc();
    check("mid no_done", done, 1'b0);

    // Preset has priority over a pending request.
    preset_all = 1'b1;
    drive(1, 1'b1, 4);
    #1;
    check("pre ready", req_ready, 0);
    cyc();
    preset_all = 1'b0;
    check("pre pn", flag_p_n, 0);
    check("pre sr", flag_s | flag_r, 0);
    check("pre early_done", done, 1'b0);
    #1;
    check("pre busy_ready", req_ready, 0);
    cyc();
    check("pre done", done, 1'b1);
    check("pre pn_back", flag_p_n, 6'h3f);
    check("pre bank", bank, 6'h3f);
    #1;
    check("pre req1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    check("pre req1_s", flag_s, 6'h10);
    if (VERIFY) cyc();
    cyc();
    check("pre req1_done", done, 1'b1);
    check("pre req1_err", err, 1'b0);

    // Q readback forced low after a set: err only when verifying.
    force_clr = 6'h04;
    do_op("force", 2, 1'b1, 2, 6'h04, 6'h00, VERIFY);
    force_clr = '0;

    // Randomized run against a schedule model of expected outputs per cycle.
    for (int c = 0; c < RN + 4; c++) begin
      e_s[c] = '0; e_r[c] = '0; e_pn[c] = '1; e_done[c] = 1'b0; e_err[c] = 1'b0;
    end
    rst = 1'b0;
    req_valid = '0;
    preset_all = 1'b0;
    cyc();
    rst = 1'b1;
    begin
      int free_at = 0;
      int rr = 0;
      for (int c = 0; c < RN; c++) begin
        int w;
        int li;
        bit lo;
        logic [NREQ-1:0] exp_ready;
        check("rnd s", flag_s, e_s[c]);
        check("rnd r", flag_r, e_r[c]);
        check("rnd pn", flag_p_n, e_pn[c]);
        check("rnd done", done, e_done[c]);
        check("rnd err", err, e_err[c]);
        check("rnd onehot", $onehot0(flag_s | flag_r), 1'b1);
        req_valid  = NREQ'($urandom);
        req_op     = NREQ'($urandom);
        req_idx    = (NREQ*FLAG_W)'($urandom);
        preset_all = ($urandom_range(0, 7) == 0);
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(rr + k) % NREQ]) w = (rr + k) % NREQ;
        exp_ready = '0;
        if (c >= free_at && !preset_all && w >= 0) exp_ready[w] = 1'b1;
        #1;
        check("rnd ready", req_ready, exp_ready);
        if (c >= free_at) begin
          if (preset_all) begin
            e_pn[c+1]   = '0;
            e_done[c+2] = 1'b1;
            free_at     = c + 2;
          end else if (w >= 0) begin
            lo = req_op[w];
            li = int'(req_idx[w*FLAG_W +: FLAG_W]);
            rr = (w + 1) % NREQ;
            if (li < NFLAG) begin
              if (lo) e_s[c+1] = 6'(1 << li);
              else    e_r[c+1] = 6'(1 << li);
              free_at = c + 2 + (VERIFY ? 1 : 0);
              e_done[free_at] = 1'b1;
            end else begin
              e_done[c+2] = 1'b1;
              e_err[c+2]  = 1'b1;
              free_at     = c + 2;
            end
          end
        end
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
